fb_count_sequencer: RTL and testbench
=====================================

// Module: fb_count_sequencer
// PURPOSE
// Sequencer for the 16-bit feedback up/down counter (midscale 0x8000 on rstb low).
// - Steers the counter's en/u_d from a strobed comparator bitstream over windows of win_len samples.
// - Captures each window result into a valid/ready output register, then optionally re-centres the counter.
// - Blocks count steps that would wrap the counter past 0x0000 or 0xFFFF.
// PARAMETERS
// WIDTH  16       counter/result width
// WIN_W  10       width of window-length field and sample counter
// MIDVAL 16'h8000 counter value after cnt_rstb low (checked by bench only)
// PORTS
// clk         in  1      system clock; counter shares this clock
// rst         in  1      asynchronous reset, active-high
// start       in  1      1-cycle pulse: latch config, re-centre counter, begin windows
// stop        in  1      1-cycle pulse: abort to IDLE, partial window discarded
// win_len     in  WIN_W  samples per window, latched on start; 0 treated as 1
// clear_each  in  1      1: re-centre counter after every capture; latched on start
// sample_en   in  1      1-cycle sample strobe
// cmp_bit     in  1      comparator decision, qualified by sample_en; 1 = count up
// cnt_q       in  WIDTH  counter output
// cnt_en      out 1      counter enable (combinational)
// cnt_u_d     out 1      counter direction, = cmp_bit
// cnt_rstb    out 1      counter async reset, active-low, registered (glitch-free)
// dout        out WIDTH  captured window result
// dout_valid  out 1      dout holds an unread result
// dout_ready  in  1      consumer accepts dout when valid & ready
// busy        out 1      state != IDLE
// sat         out 1      sticky: a count step was blocked at a rail
// overrun     out 1      sticky: unread result overwritten, or sample dropped
// BEHAVIOUR
// - Reset (rst high): state IDLE, cnt_rstb=0, dout=0, dout_valid=0, sat=0, overrun=0, sample count=0.
// - States: IDLE, INIT, RUN, CAPT, CLR.
//   IDLE: cnt_rstb=1, cnt_en=0; start -> INIT.
//   INIT: cnt_rstb=0 for 1 cycle; config latched; sat/overrun cleared; -> RUN.
//   RUN: cnt_en = sample_en & ~block. Every sample_en increments the sample count, blocked or not.
//     When the count reaches win_len on a strobe, the count resets to 0 -> CAPT.
//   CAPT: dout<=cnt_q (includes the final sample), dout_valid<=1 -> CLR if clear_each, else -> RUN.
//   CLR: cnt_rstb=0 for 1 cycle -> RUN.
// - block = (cmp_bit & cnt_q==all-ones) | (~cmp_bit & cnt_q==0); a blocked strobe sets sat.
// - Timing: counter changes on the clk edge at which cnt_en=1. Result latency is 1 cycle after the last strobe.
// - Required sample_en spacing is >=3 cycles. A strobe seen in CAPT or CLR is dropped and sets overrun.
// - Handshake: dout_valid clears on the edge with dout_ready=1.
//   Capture while dout_valid=1 and dout_ready=0: dout overwritten, dout_valid stays 1, overrun set.
//   Capture and handshake in the same cycle: new data, dout_valid=1, no overrun.
// - stop: any state -> IDLE next cycle. Counter holds its value; dout/dout_valid keep their values.
// - start while busy: restart via INIT; the sample count clears.
// - Simultaneous start & stop: start wins.
// - rst mid-window: immediate return to reset values; counter held at midscale while rst is high.
// TESTING
// 1. start, win_len=4, clear_each=1, cmp 1,1,1,0 -> dout=0x8002, valid; counter back to 0x8000.
// 2. win_len=3, clear_each=0, all ones over two windows -> dout 0x8003 then 0x8006.
// 3. Counter driven to 0xFFFF, cmp=1 strobe -> cnt_en=0, cnt_q stays 0xFFFF, sat=1.
//    Same at 0x0000 with cmp=0.
// 4. dout_ready=0 across two captures -> second value in dout, overrun=1.
//    Then a ready pulse -> dout_valid=0.
// 5. Strobe one cycle after final strobe (in CAPT) -> dropped, overrun=1, next window counts win_len fresh.
// 6. rst asserted mid-window -> cnt_rstb=0, dout_valid=0, IDLE.
//    win_len=0 after restart -> capture on every strobe.

Source files
------------

// File: rtl/fb_count_sequencer.sv
// Window sequencer for a 16-bit feedback up/down counter: steers en/u_d from a strobed
// comparator stream, captures one result per window and optionally re-centres the counter.
module fb_count_sequencer #(
  parameter int WIDTH = 16,
  parameter int WIN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
  input  logic             clear_each,
  input  logic             sample_en,
  input  logic             cmp_bit,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_u_d,
  output logic             cnt_rstb,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             sat,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, INIT, RUN, CAPT, CLR} state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] smp_cnt_q;
  logic             clear_q;
  logic             cnt_rstb_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             sat_q;
  logic             ovr_q;

  logic             block;
  logic             strobe_run;
  logic             last_smp;
  logic             blind_strobe;
  logic [WIN_W-1:0] len_eff;

  always_comb begin
    block        = (cmp_bit & (&cnt_q)) | (~cmp_bit & ~(|cnt_q));
    strobe_run   = (state_q == RUN) & sample_en;
    blind_strobe = ((state_q == CAPT) | (state_q == CLR)) & sample_en;
    len_eff      = (len_q == '0) ? WIN_W'(1) : len_q;
    last_smp     = (smp_cnt_q + WIN_W'(1)) == len_eff;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = INIT;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        INIT:    state_d = RUN;
        RUN:     if (sample_en && last_smp) state_d = CAPT;
        CAPT:    state_d = clear_q ? CLR : RUN;
        CLR:     state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // cnt_rstb is decoded from the next state so it leaves a flop and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_rstb_q <= 1'b0;
      len_q      <= '0;
      clear_q    <= 1'b0;
      smp_cnt_q  <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_rstb_q <= ~((state_d == INIT) | (state_d == CLR));
      if (start) begin
        len_q   <= win_len;
        clear_q <= clear_each;
      end
      if (start || stop) begin
        smp_cnt_q <= '0;
      end else if (strobe_run) begin
        smp_cnt_q <= last_smp ? '0 : smp_cnt_q + WIN_W'(1);
      end
      if (state_q == CAPT) begin
        dout_q  <= cnt_q;
        valid_q <= 1'b1;
      end else if (dout_ready) begin
        valid_q <= 1'b0;
      end
      if (state_q == INIT) begin
        sat_q <= 1'b0;
        ovr_q <= 1'b0;
      end else begin
        if (strobe_run && block) sat_q <= 1'b1;
        if ((state_q == CAPT && valid_q && !dout_ready) || blind_strobe) ovr_q <= 1'b1;
      end
    end
  end

  assign cnt_en     = strobe_run & ~block;
  assign cnt_u_d    = cmp_bit;
  assign cnt_rstb   = cnt_rstb_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign sat        = sat_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fb_count_sequencer.sv
// Bench for fb_count_sequencer: owns the up/down counter, tracks windows with a cycle-level
// model and compares every DUT output each cycle, plus hand-computed literal checks.
module tb_fb_count_sequencer;

  localparam int          WIDTH  = 16;
  localparam int          WIN_W  = 10;
  localparam logic [15:0] MIDVAL = 16'h8000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, stop = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             clear_each = 1'b0;
  logic             sample_en = 1'b0, cmp_bit = 1'b0;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_en, cnt_u_d, cnt_rstb;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, busy, sat, overrun;
  logic             dout_ready = 1'b0;
  logic             tb_load = 1'b0;
  logic [WIDTH-1:0] tb_load_val = '0;

  int n_vec = 0;
  int n_err = 0;

  fb_count_sequencer #(.WIDTH(WIDTH), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len),
    .clear_each(clear_each), .sample_en(sample_en), .cmp_bit(cmp_bit), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_u_d(cnt_u_d), .cnt_rstb(cnt_rstb), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .sat(sat),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // External counter; tb_load lets the bench jump straight to a rail.
  always_ff @(posedge clk or negedge cnt_rstb) begin
    if (!cnt_rstb)    cnt_q <= MIDVAL;
    else if (tb_load) cnt_q <= tb_load_val;
    else if (cnt_en)  cnt_q <= cnt_u_d ? cnt_q + 16'd1 : cnt_q - 16'd1;
  end

  // Model: m_after counts cycles since a window closed (1 = capture cycle, 2 = re-centre cycle).
  logic        m_busy = 0, m_init = 0, m_clear = 0, m_valid = 0, m_sat = 0, m_ovr = 0;
  logic [15:0] m_cnt = MIDVAL, m_dout = 0;
  int          m_len = 0, m_n = 0, m_after = 0;

  function automatic logic at_rail(logic [15:0] c, logic up);
    return (up && c == 16'hFFFF) || (!up && c == 16'h0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    $display("check %s: got %0h expected %0h", nm, act, exp);
    chk(nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_init = 0; m_after = 0; m_n = 0; m_cnt = MIDVAL;
      m_dout = 0; m_valid = 0; m_sat = 0; m_ovr = 0;
    end else begin
      logic running, closing;
      running = m_busy && !m_init && m_after == 0;
      closing = 0;
      if (m_busy && m_after == 1) begin
        if (m_valid && !dout_ready) m_ovr = 1;
        m_dout = m_cnt; m_valid = 1;
      end else if (dout_ready) m_valid = 0;
      if (m_busy && m_after != 0 && sample_en) m_ovr = 1;
      if (m_init) begin m_sat = 0; m_ovr = 0; end
      if (running && sample_en) begin
        if (at_rail(m_cnt, cmp_bit)) m_sat = 1;
        else m_cnt = cmp_bit ? m_cnt + 16'd1 : m_cnt - 16'd1;
        m_n++;
        if (m_n >= ((m_len == 0) ? 1 : m_len)) begin m_n = 0; closing = 1; end
      end
      if (tb_load) m_cnt = tb_load_val;
      m_after = (m_after == 1 && m_clear) ? 2 : 0;
      if (closing) m_after = 1;
      m_init = 0;
      if (start) begin
        m_busy = 1; m_init = 1; m_after = 0; m_n = 0; m_len = int'(win_len); m_clear = clear_each;
      end else if (stop) begin
        m_busy = 0; m_after = 0; m_n = 0;
      end
      if (m_busy && (m_init || m_after == 2)) m_cnt = MIDVAL;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("cnt_q", cnt_q, m_cnt);
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("sat", sat, m_sat);
    chk("overrun", overrun, m_ovr);
    chk("busy", busy, m_busy);
    chk("cnt_rstb", cnt_rstb, !(rst || (m_busy && (m_init || m_after == 2))));
    chk("cnt_en", cnt_en, m_busy && !m_init && m_after == 0 && sample_en && !at_rail(m_cnt, cmp_bit));
    chk("cnt_u_d", cnt_u_d, cmp_bit);
  end

  task automatic strobe(input logic b);
    sample_en = 1; cmp_bit = b;
    @(negedge clk); sample_en = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic go(input int l, input logic c);
    win_len = WIN_W'(l); clear_each = c; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
  endtask

  task automatic ready_pulse();
    dout_ready = 1; @(negedge clk); dout_ready = 0;
  endtask

  task automatic load(input logic [15:0] v);
    tb_load = 1; tb_load_val = v; @(negedge clk); tb_load = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("reset cnt_rstb", cnt_rstb, 0);
    lit("reset dout", dout, 0);
    lit("reset dout_valid", dout_valid, 0);
    lit("reset busy", busy, 0);
    rst = 0; @(negedge clk);
    lit("idle cnt_q", cnt_q, 16'h8000);

    // 1: window of 4, re-centre after capture
    go(4, 1);
    strobe(1); strobe(1); strobe(1); strobe(0);
    lit("t1 dout", dout, 16'h8002);
    lit("t1 valid", dout_valid, 1);
    lit("t1 recentred", cnt_q, 16'h8000);
    ready_pulse();
    lit("t1 valid after ready", dout_valid, 0);

    // 2: window of 3, no re-centre, two windows
    go(3, 0);
    repeat (3) strobe(1);
    lit("t2 dout w1", dout, 16'h8003);
    ready_pulse();
    repeat (3) strobe(1);
    lit("t2 dout w2", dout, 16'h8006);
    lit("t2 overrun", overrun, 0);
    ready_pulse();

    // 3: rails
    go(8, 0);
    load(16'hFFFF);
    sample_en = 1; cmp_bit = 1; #1;
    lit("t3 en at top", cnt_en, 0);
    @(negedge clk); sample_en = 0;
    lit("t3 hold top", cnt_q, 16'hFFFF);
    lit("t3 sat top", sat, 1);
    strobe(0);
    lit("t3 step down", cnt_q, 16'hFFFE);
    go(8, 0);
    lit("t3 sat cleared", sat, 0);
    load(16'h0000);
    sample_en = 1; cmp_bit = 0; #1;
    lit("t3 en at bottom", cnt_en, 0);
    @(negedge clk); sample_en = 0;
    lit("t3 hold bottom", cnt_q, 16'h0000);
    lit("t3 sat bottom", sat, 1);

    // 4: two captures without ready
    go(2, 0);
    repeat (4) strobe(1);
    lit("t4 dout", dout, 16'h8004);
    lit("t4 valid", dout_valid, 1);
    lit("t4 overrun", overrun, 1);
    ready_pulse();
    lit("t4 valid cleared", dout_valid, 0);

    // 5: strobe landing in the capture cycle is dropped
    go(2, 1);
    strobe(0);
    sample_en = 1; cmp_bit = 0; @(negedge clk);
    cmp_bit = 1; @(negedge clk);
    sample_en = 0; @(negedge clk); @(negedge clk);
    lit("t5 overrun", overrun, 1);
    lit("t5 dout", dout, 16'h7FFE);
    ready_pulse();
    strobe(1); strobe(1);
    lit("t5 fresh window", dout, 16'h8002);
    lit("t5 recentred", cnt_q, 16'h8000);

    // 6: stop, reset mid-window, then win_len=0
    go(4, 0);
    strobe(1); strobe(1);
    stop = 1; @(negedge clk); stop = 0; @(negedge clk);
    lit("t6 stop busy", busy, 0);
    lit("t6 stop holds cnt", cnt_q, 16'h8002);
    go(4, 0);
    strobe(1);
    rst = 1; @(negedge clk);
    lit("t6 rst cnt_rstb", cnt_rstb, 0);
    lit("t6 rst valid", dout_valid, 0);
    lit("t6 rst busy", busy, 0);
    lit("t6 rst cnt", cnt_q, 16'h8000);
    rst = 0; @(negedge clk);
    go(0, 0);
    dout_ready = 1;
    strobe(1); strobe(1); strobe(1);
    lit("t6 len0 dout", dout, 16'h8003);
    strobe(0);
    lit("t6 len0 dout down", dout, 16'h8002);
    dout_ready = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
